// File: rtl/vga_pkg.sv
// Shared constants and types for the pixel-write framebuffer and VGA scanout.
// Default timing is 640x480@60 with a 160x120 framebuffer.
package vga_pkg;

   localparam int unsigned VGA_CLK_DIV = 2;

   localparam int unsigned VGA_H_VIS  = 640;
   localparam int unsigned VGA_H_FP   = 16;
   localparam int unsigned VGA_H_SYNC = 96;
   localparam int unsigned VGA_H_BP   = 48;

   localparam int unsigned VGA_V_VIS  = 480;
   localparam int unsigned VGA_V_FP   = 10;
   localparam int unsigned VGA_V_SYNC = 2;
   localparam int unsigned VGA_V_BP   = 33;

   localparam int unsigned FB_W     = 160;
   localparam int unsigned FB_H     = 120;
   localparam int unsigned FB_AW    = 15;
   localparam int unsigned FB_DEPTH = FB_W * FB_H;

   typedef logic [2:0] colour_t;

   localparam colour_t              BG_COLOUR = 3'b000;
   localparam logic [FB_AW-1:0]     FB_LAST   = FB_AW'(FB_DEPTH - 1);

   typedef enum logic {
      ST_IDLE,
      ST_CLEAR
   } clr_state_e;

   // y*160 + x built from shifts: y*128 + y*32 + x.
   function automatic logic [FB_AW-1:0] fb_addr(input logic [6:0] y, input logic [7:0] x);
      return {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};
   endfunction

endpackage

// File: rtl/vga_pixel_scanout_if.sv
// Pixel-write port between the glyph drawers (master) and the framebuffer (slave).
interface vga_pixel_scanout_if;
   import vga_pkg::*;

   logic [7:0] x;
   logic [6:0] y;
   colour_t    colour;
   logic       writeEn;

   modport master (output x, y, colour, writeEn);
   modport slave  (input  x, y, colour, writeEn);

endinterface

// File: rtl/vga_fb_ram.sv
// Simple dual-port framebuffer RAM: one write port, one registered read port.
// Read-before-write: a same-address read returns the old contents.
module vga_fb_ram
   import vga_pkg::*;
#(
   parameter int unsigned DEPTH = FB_DEPTH,
   parameter int unsigned AW    = FB_AW
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  colour_t       wr_data,
   input  logic [AW-1:0] rd_addr,
   output colour_t       rd_data
);

   colour_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/vga_pixel_scanout.sv
// 160x120x3 framebuffer with single-pixel writes, scanned out as 640x480 VGA in 4x4 blocks.
// Optional clear sweep enabled by defining VGA_CLEAR_EN.
module vga_pixel_scanout
   import vga_pkg::*;
#(
   parameter int unsigned CLK_DIV = VGA_CLK_DIV,
   parameter int unsigned H_VIS   = VGA_H_VIS,
   parameter int unsigned H_FP    = VGA_H_FP,
   parameter int unsigned H_SYNC  = VGA_H_SYNC,
   parameter int unsigned H_BP    = VGA_H_BP,
   parameter int unsigned V_VIS   = VGA_V_VIS,
   parameter int unsigned V_FP    = VGA_V_FP,
   parameter int unsigned V_SYNC  = VGA_V_SYNC,
   parameter int unsigned V_BP    = VGA_V_BP
) (
   input  logic                clk,
   input  logic                resetn,
   vga_pixel_scanout_if.slave  wr,
   input  logic                clear_req,
   output logic                clear_busy,
   output logic [7:0]          vga_r,
   output logic [7:0]          vga_g,
   output logic [7:0]          vga_b,
   output logic                vga_hs,
   output logic                vga_vs,
   output logic                vga_blank_n,
   output logic                vga_sync_n,
   output logic                vga_clk
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

   localparam logic [9:0] H_VIS_L  = 10'(H_VIS);
   localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
   localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
   localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_VIS_L  = 10'(V_VIS);
   localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
   localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);
   localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);

   logic [DIV_W-1:0] div_cnt;
   logic [9:0]       h_cnt;
   logic [9:0]       v_cnt;
   logic             pix_en;
   logic             hs_n;
   logic             vs_n;
   logic             visible;
   logic             hs_d1;
   logic             vs_d1;
   logic             vis_d1;

   logic [FB_AW-1:0] rd_addr;
   colour_t          rd_data;
   logic             wr_ok;
   logic [FB_AW-1:0] usr_addr;
   logic             ram_we;
   logic [FB_AW-1:0] ram_waddr;
   colour_t          ram_wdata;

   assign pix_en     = (div_cnt == DIV_LAST);
   assign vga_clk    = (div_cnt < DIV_HALF);
   assign vga_sync_n = 1'b0;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         div_cnt <= '0;
         h_cnt   <= '0;
         v_cnt   <= '0;
      end else begin
         div_cnt <= pix_en ? '0 : div_cnt + 1'b1;
         if (pix_en) begin
            if (h_cnt == H_LAST) begin
               h_cnt <= '0;
               v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
            end else begin
               h_cnt <= h_cnt + 10'd1;
            end
         end
      end
   end

   assign hs_n    = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
   assign vs_n    = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
   assign visible = (h_cnt < H_VIS_L) && (v_cnt < V_VIS_L);

   // Blanking addresses fall outside the RAM, so park the read on entry 0.
   assign rd_addr = visible ? fb_addr(v_cnt[8:2], h_cnt[9:2]) : '0;

   // Stage 1 runs alongside the RAM read, stage 2 drives the pins.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hs_d1       <= 1'b1;
         vs_d1       <= 1'b1;
         vis_d1      <= 1'b0;
         vga_hs      <= 1'b1;
         vga_vs      <= 1'b1;
         vga_blank_n <= 1'b0;
         vga_r       <= '0;
         vga_g       <= '0;
         vga_b       <= '0;
      end else begin
         hs_d1       <= hs_n;
         vs_d1       <= vs_n;
         vis_d1      <= visible;
         vga_hs      <= hs_d1;
         vga_vs      <= vs_d1;
         vga_blank_n <= vis_d1;
         vga_r       <= vis_d1 ? {8{rd_data[2]}} : '0;
         vga_g       <= vis_d1 ? {8{rd_data[1]}} : '0;
         vga_b       <= vis_d1 ? {8{rd_data[0]}} : '0;
      end
   end

   assign wr_ok    = wr.writeEn && (wr.x < 8'(FB_W)) && (wr.y < 7'(FB_H));
   assign usr_addr = fb_addr(wr.y, wr.x);

`ifdef VGA_CLEAR_EN
   clr_state_e       state_q;
   clr_state_e       state_d;
   logic [FB_AW-1:0] clr_addr_q;
   logic [FB_AW-1:0] clr_addr_d;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= ST_IDLE;
         clr_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      clear_busy = 1'b0;
      ram_we     = wr_ok;
      ram_waddr  = usr_addr;
      ram_wdata  = wr.colour;
      case (state_q)
         ST_IDLE: begin
            if (clear_req) begin
               state_d    = ST_CLEAR;
               clr_addr_d = '0;
            end
         end
         ST_CLEAR: begin
            clear_busy = 1'b1;
            ram_we     = 1'b1;
            ram_waddr  = clr_addr_q;
            ram_wdata  = BG_COLOUR;
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == FB_LAST) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end
`else
   logic clear_req_unused;

   assign clear_req_unused = clear_req;
   assign clear_busy       = 1'b0;
   assign ram_we           = wr_ok;
   assign ram_waddr        = usr_addr;
   assign ram_wdata        = wr.colour;
`endif

   vga_fb_ram #(
      .DEPTH (FB_DEPTH),
      .AW    (FB_AW)
   ) u_ram (
      .clk     (clk),
      .we      (ram_we),
      .wr_addr (ram_waddr),
      .wr_data (ram_wdata),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_vga_pixel_scanout.sv
// Directed bench for vga_pixel_scanout; vertical timing is shortened to 14 lines so
// whole frames fit in a short run (visible 8, front porch 2, sync 2, back porch 2).
module tb_vga_pixel_scanout;
   import vga_pkg::*;

   logic       clk;
   logic       resetn;
   logic       clear_req;
   logic       clear_busy;
   logic [7:0] vga_r;
   logic [7:0] vga_g;
   logic [7:0] vga_b;
   logic       vga_hs;
   logic       vga_vs;
   logic       vga_blank_n;
   logic       vga_sync_n;
   logic       vga_clk;

   int cyc;
   int n_assert;
   int n_fail;

   vga_pixel_scanout_if wr_if ();

   vga_pixel_scanout #(
      .V_VIS  (8),
      .V_FP   (2),
      .V_SYNC (2),
      .V_BP   (2)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .wr          (wr_if),
      .clear_req   (clear_req),
      .clear_busy  (clear_busy),
      .vga_r       (vga_r),
      .vga_g       (vga_g),
      .vga_b       (vga_b),
      .vga_hs      (vga_hs),
      .vga_vs      (vga_vs),
      .vga_blank_n (vga_blank_n),
      .vga_sync_n  (vga_sync_n),
      .vga_clk     (vga_clk)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // cyc == N at the falling edge that follows the Nth rising edge after reset release.
   always @(posedge clk) begin
      if (!resetn) cyc <= 0;
      else         cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      for (int i = 0; i < 100000 && cyc < n; i++) @(negedge clk);
      if (cyc != n) begin
         n_fail++;
         $error("FAIL wait_cyc: observed cycle %0d expected %0d", cyc, n);
      end
   endtask

   task automatic write_px(input int px, input int py, input int pc);
      wr_if.x       = 8'(px);
      wr_if.y       = 7'(py);
      wr_if.colour  = 3'(pc);
      wr_if.writeEn = 1'b1;
      @(negedge clk);
      wr_if.writeEn = 1'b0;
   endtask

   task automatic pulse_reset();
      resetn = 1'b0;
      #1;
      check("rst_hs", vga_hs, 1);
      check("rst_vs", vga_vs, 1);
      check("rst_blank", vga_blank_n, 0);
      check("rst_r", vga_r, 0);
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_assert      = 0;
      n_fail        = 0;
      resetn        = 1'b0;
      clear_req     = 1'b0;
      wr_if.x       = '0;
      wr_if.y       = '0;
      wr_if.colour  = '0;
      wr_if.writeEn = 1'b0;

      repeat (3) @(negedge clk);
      check("reset_hs", vga_hs, 1);
      check("reset_vs", vga_vs, 1);
      check("reset_blank", vga_blank_n, 0);
      check("reset_rgb", {vga_r, vga_g, vga_b}, 0);
      check("reset_sync_n", vga_sync_n, 0);
      check("reset_busy", clear_busy, 0);
      check("reset_vga_clk", vga_clk, 1);
      resetn = 1'b1;

      wait_cyc(1);
      check("vga_clk_c1", vga_clk, 0);
      check("blank_c1", vga_blank_n, 0);
      wait_cyc(2);
      check("vga_clk_c2", vga_clk, 1);
      check("blank_c2", vga_blank_n, 1);

      write_px(0, 0, 3'b100);
      write_px(1, 0, 3'b000);
      write_px(2, 1, 3'b001);
      write_px(0, 5, 3'b000);
      write_px(0, 6, 3'b000);
      write_px(159, 119, 3'b011);
      write_px(160, 5, 3'b111);
      write_px(5, 120, 3'b111);

      wait_cyc(30);
      check("mem_br_cyan", dut.u_ram.mem[19199], 3'b011);
      check("mem_x160_drop", dut.u_ram.mem[800], 3'b000);
      check("mem_x160_nowrap", dut.u_ram.mem[960], 3'b000);

      wait_cyc(1281); check("blank_h639", vga_blank_n, 1);
      wait_cyc(1282); check("blank_h640", vga_blank_n, 0);
      wait_cyc(1313); check("hs_h655", vga_hs, 1);
      wait_cyc(1314); check("hs_h656", vga_hs, 0);
      wait_cyc(1505); check("hs_h751", vga_hs, 0);
      wait_cyc(1506); check("hs_h752", vga_hs, 1);

      wait_cyc(1601); check("px_before_line1", vga_r, 8'h00);
      wait_cyc(1602); check("px00_red", {vga_r, vga_g, vga_b}, 24'hFF0000);
      wait_cyc(1609); check("px00_red_end", vga_r, 8'hFF);
      wait_cyc(1610); check("px10_black", {vga_r, vga_g, vga_b}, 24'h000000);
      wait_cyc(2913); check("hs_line1_h655", vga_hs, 1);
      wait_cyc(2914); check("hs_period", vga_hs, 0);

      // Block (2,1) is read at the rising edge that also writes it.
      wait_cyc(6416);
      write_px(2, 1, 3'b010);
      wait_cyc(6418); check("rbw_old", {vga_g, vga_b}, 16'h00FF);
      wait_cyc(6419); check("rbw_new", {vga_g, vga_b}, 16'hFF00);

      wait_cyc(11203); check("blank_v7", vga_blank_n, 1);
      wait_cyc(12803); check("blank_v8", vga_blank_n, 0);
      wait_cyc(16001); check("vs_v9", vga_vs, 1);
      wait_cyc(16002); check("vs_v10", vga_vs, 0);
      wait_cyc(19201); check("vs_v11", vga_vs, 0);
      wait_cyc(19202); check("vs_v12", vga_vs, 1);
      wait_cyc(28818); check("next_frame_green", {vga_g, vga_b}, 16'hFF00);
      wait_cyc(38401); check("vs2_v9", vga_vs, 1);
      wait_cyc(38402); check("vs_frame_period", vga_vs, 0);

      wait_cyc(39803);
      check("pre_rst_hs_low", vga_hs, 0);
      check("pre_rst_vs_low", vga_vs, 0);
      pulse_reset();

      wait_cyc(1); check("restart_blank_c1", vga_blank_n, 0);
      wait_cyc(2); check("restart_blank_c2", vga_blank_n, 1);
      wait_cyc(1313); check("restart_hs_h655", vga_hs, 1);
      wait_cyc(1314); check("restart_hs_h656", vga_hs, 0);
      wait_cyc(1602); check("restart_fb_intact", {vga_r, vga_g, vga_b}, 24'hFF0000);

      wait_cyc(3803);
      check("pre_rst_visible", vga_blank_n, 1);
      pulse_reset();

      wait_cyc(10);
      check("busy_before_req", clear_busy, 0);
      clear_req = 1'b1;
      @(negedge clk);
      clear_req = 1'b0;
`ifdef VGA_CLEAR_EN
      check("busy_rise", clear_busy, 1);
`else
      check("busy_const0", clear_busy, 0);
`endif
      wait_cyc(100);
      write_px(0, 0, 3'b111);
`ifdef VGA_CLEAR_EN
      for (int i = 0; i < 25000 && clear_busy; i++) @(negedge clk);
      check("busy_fall_cycle", cyc, 19211);
      check("clear_mem0", dut.u_ram.mem[0], 3'b000);
      check("clear_mem162", dut.u_ram.mem[162], 3'b000);
      check("clear_mem19199", dut.u_ram.mem[19199], 3'b000);
      wait_cyc(24002);
      check("clear_blank", vga_blank_n, 1);
      check("clear_px00_black", {vga_r, vga_g, vga_b}, 24'h000000);
`else
      wait_cyc(19211);
      check("busy_still0", clear_busy, 0);
      check("noclr_mem0", dut.u_ram.mem[0], 3'b111);
      check("noclr_mem162", dut.u_ram.mem[162], 3'b010);
      check("noclr_mem19199", dut.u_ram.mem[19199], 3'b011);
      wait_cyc(24002);
      check("noclr_blank", vga_blank_n, 1);
      check("noclr_px00_white", {vga_r, vga_g, vga_b}, 24'hFFFFFF);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
